// File: rtl/screen_to_world.sv
// screen_to_world: maps unsigned integer pixel coordinates back to binary16
// world-space positions, world = (pix - HALF_SCREEN_PIX) * PIX_SCALE per dim.
// One input accepted per cycle, no backpressure. An input sampled at edge N
// produces its registered result at edge N+4. Dims are independent datapath
// lanes that share one valid pipeline. in_bounds travels alongside the data.
module screen_to_world #(
  parameter int                 DIMS            = 2,
  parameter logic [DIMS*16-1:0] HALF_SCREEN_PIX = 32'h005A_00A0,
  parameter logic [DIMS*16-1:0] PIX_SCALE       = 32'h16C1_0CCD
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [DIMS*16-1:0] pix,
  input  logic               data_valid_in,
  output logic [DIMS*16-1:0] result,
  output logic               in_bounds,
  output logic               data_valid_out,
  output logic               busy
);

  // ---------------------------------------------------------------------------
  // Valid pipeline: s0 = sampled input, s1..s3 = compute stages, output = s4
  // ---------------------------------------------------------------------------
  logic r_s0_valid;
  logic r_s1_valid;
  logic r_s2_valid;
  logic r_s3_valid;
  logic r_out_valid;

  // Datapath registers. Valid bits qualify them, so they carry no reset.
  logic [DIMS*16-1:0] r_s0_pix;
  logic signed [16:0] r_s1_off    [DIMS];
  logic               r_s1_inb;
  logic [DIMS-1:0]    r_s2_sign;
  logic [31:0]        r_s2_mag    [DIMS];
  logic               r_s2_inb;
  logic [DIMS-1:0]    r_s3_sign;
  logic [DIMS-1:0]    r_s3_zero;
  logic signed [6:0]  r_s3_exp    [DIMS];
  logic [9:0]         r_s3_mant   [DIMS];
  logic [DIMS-1:0]    r_s3_guard;
  logic [DIMS-1:0]    r_s3_sticky;
  logic               r_s3_inb;

  // Output registers
  logic [DIMS*16-1:0] r_result;
  logic               r_in_bounds;

  // Combinational stage results
  logic signed [16:0] w_off       [DIMS];
  logic [DIMS-1:0]    w_lane_inb;
  logic signed [32:0] w_prod      [DIMS];
  logic [DIMS-1:0]    w_sign;
  logic [31:0]        w_mag       [DIMS];
  logic [4:0]         w_lead      [DIMS];
  logic [31:0]        w_norm      [DIMS];
  logic signed [6:0]  w_exp       [DIMS];
  logic [DIMS-1:0]    w_zero;
  logic [DIMS-1:0]    w_rnd_up;
  logic [10:0]        w_mant_r    [DIMS];
  logic signed [6:0]  w_exp_r     [DIMS];
  logic [DIMS*16-1:0] w_half;

  // S1: signed offset from the screen centre and per-lane on-screen test
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    w_lane_inb = '0;
    for (int i = 0; i < DIMS; i++) begin
      w_off[i]      = $signed({1'b0, r_s0_pix[i*16 +: 16]})
                    - $signed({1'b0, HALF_SCREEN_PIX[i*16 +: 16]});
      // Full screen width is 2*HALF, compared at 17 bits so it cannot wrap.
      w_lane_inb[i] = {1'b0, r_s0_pix[i*16 +: 16]} < {HALF_SCREEN_PIX[i*16 +: 16], 1'b0};
    end
  end

  // S2: Q16.16 product, split into sign and 32-bit magnitude
  always_comb begin
    w_sign = '0;
    for (int i = 0; i < DIMS; i++) begin
      w_prod[i] = 33'(r_s1_off[i]) * 33'($signed({1'b0, PIX_SCALE[i*16 +: 16]}));
      w_sign[i] = w_prod[i][32];
      // |off| * scale < 2^32, so the negated product always fits 32 bits.
      w_mag[i]  = w_prod[i][32] ? 32'(-w_prod[i]) : w_prod[i][31:0];
    end
  end

  // S3: leading-one detect, normalise, extract mantissa/guard/sticky
  always_comb begin
    w_zero = '0;
    for (int i = 0; i < DIMS; i++) begin
      w_lead[i] = 5'd0;
      for (int b = 0; b < 32; b++) begin
        if (r_s2_mag[i][b]) w_lead[i] = 5'(b);
      end
      w_norm[i] = r_s2_mag[i] << (5'd31 - w_lead[i]);
      // Leading one at bit p of a Q16.16 value is 2^(p-16); biased by 15.
      w_exp[i]  = $signed({2'b00, w_lead[i]}) - 7'sd1;
      w_zero[i] = (r_s2_mag[i] == 32'd0);
    end
  end

  // S4: round to nearest even, then pack with zero/underflow/overflow handling
  always_comb begin
    w_rnd_up = '0;
    w_half   = '0;
    for (int i = 0; i < DIMS; i++) begin
      w_rnd_up[i] = r_s3_guard[i] & (r_s3_sticky[i] | r_s3_mant[i][0]);
      w_mant_r[i] = {1'b0, r_s3_mant[i]} + {10'd0, w_rnd_up[i]};
      // A mantissa carry-out leaves the 10 fraction bits at zero and bumps the exponent.
      w_exp_r[i]  = r_s3_exp[i] + (w_mant_r[i][10] ? 7'sd1 : 7'sd0);
      if (r_s3_zero[i]) begin
        w_half[i*16 +: 16] = 16'h0000;
      end else if (w_exp_r[i] <= 7'sd0) begin
        w_half[i*16 +: 16] = {r_s3_sign[i], 15'd0};
      end else if (w_exp_r[i] >= 7'sd31) begin
        w_half[i*16 +: 16] = {r_s3_sign[i], 5'h1F, 10'd0};
      end else begin
        w_half[i*16 +: 16] = {r_s3_sign[i], w_exp_r[i][4:0], w_mant_r[i][9:0]};
      end
    end
  end

  // Valid chain and output registers; reset drops everything in flight
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_s0_valid  <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_in_bounds <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // reads the previous cycle's value of the stage before it.
      r_s0_valid  <= data_valid_in;
      r_s1_valid  <= r_s0_valid;
      r_s2_valid  <= r_s1_valid;
      r_s3_valid  <= r_s2_valid;
      r_out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_result    <= w_half;
        r_in_bounds <= r_s3_inb;
      end
    end
  end

  // Datapath stage registers, loaded every cycle
  always_ff @(posedge clk_in) begin
    // NOTE: these registers are deliberately left without reset: nothing reads
    // them unless the matching valid bit, which does reset, is set.
    r_s0_pix <= pix;
    r_s1_inb <= &w_lane_inb;
    r_s2_inb <= r_s1_inb;
    r_s3_inb <= r_s2_inb;
    r_s2_sign <= w_sign;
    r_s3_sign <= r_s2_sign;
    r_s3_zero <= w_zero;
    for (int i = 0; i < DIMS; i++) begin
      r_s1_off[i]    <= w_off[i];
      r_s2_mag[i]    <= w_mag[i];
      r_s3_exp[i]    <= w_exp[i];
      r_s3_mant[i]   <= w_norm[i][30:21];
      r_s3_guard[i]  <= w_norm[i][20];
      r_s3_sticky[i] <= |w_norm[i][19:0];
    end
  end

  assign result         = r_result;
  assign in_bounds      = r_in_bounds;
  assign data_valid_out = r_out_valid;
  assign busy           = r_s0_valid | r_s1_valid | r_s2_valid | r_s3_valid | r_out_valid;

endmodule

// File: tb/tb_screen_to_world.sv
// Testbench for screen_to_world: directed vectors with hand-computed binary16
// results, latency/reset/streaming checks, and random vectors compared against
// a real-arithmetic round-to-nearest-even reference.
module tb_screen_to_world;

  localparam int HALF_X  = 160;
  localparam int HALF_Y  = 90;
  localparam int SCALE_X = 32'h0CCD;
  localparam int SCALE_Y = 32'h16C1;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [31:0] pix;
  logic        data_valid_in;
  logic [31:0] result;
  logic        in_bounds;
  logic        data_valid_out;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic        inb;
  } exp_t;
  exp_t exp_q[$];

  screen_to_world dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .pix            (pix),
    .data_valid_in  (data_valid_in),
    .result         (result),
    .in_bounds      (in_bounds),
    .data_valid_out (data_valid_out),
    .busy           (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: exact Q16.16 product converted with real arithmetic, RNE, no subnormals.
  function automatic logic [15:0] ref_half(input int p, input int half, input int scale);
    longint prod;
    logic   s;
    real    a, m, fl, frac;
    int     e, mi, be;
    prod = (longint'(p) - longint'(half)) * longint'(scale);
    if (prod == 0) return 16'h0000;
    s = (prod < 0);
    a = (s ? real'(-prod) : real'(prod)) / 65536.0;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m    = (a - 1.0) * 1024.0;
    fl   = $floor(m);
    frac = m - fl;
    mi   = $rtoi(fl);
    if (frac > 0.5 || (frac == 0.5 && (mi % 2) == 1)) mi++;
    if (mi == 1024) begin mi = 0; e++; end
    be = e + 15;
    if (be <= 0)  return {s, 15'd0};
    if (be >= 31) return {s, 5'h1F, 10'd0};
    return {s, 5'(be), 10'(mi)};
  endfunction

  // Drive one sample at the falling edge and queue what it must produce.
  task automatic send(input int x, input int y, input logic [15:0] rx,
                      input logic [15:0] ry, input logic inb);
    exp_t e;
    @(negedge clk_in);
    pix           = {16'(y), 16'(x)};
    data_valid_in = 1'b1;
    e.res = {ry, rx};
    e.inb = inb;
    exp_q.push_back(e);
  endtask

  task automatic send_ref(input int x, input int y);
    send(x, y, ref_half(x, HALF_X, SCALE_X), ref_half(y, HALF_Y, SCALE_Y),
         (x < 2 * HALF_X) && (y < 2 * HALF_Y));
  endtask

  task automatic idle();
    @(negedge clk_in);
    data_valid_in = 1'b0;
  endtask

  // Bounded wait for every queued result to come out.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk_in);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // Output monitor: every pulse must match the next expected sample in order.
  always begin
    exp_t e;
    @(posedge clk_in);
    #1;
    if (!rst && data_valid_out) begin
      if (exp_q.size() == 0) begin
        check("stray_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("in_bounds", {31'd0, in_bounds}, {31'd0, e.inb});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    pix           = 32'd0;
    data_valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    // Valid input during reset must be ignored.
    pix           = {16'd90, 16'd160};
    data_valid_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("rst_dvo", {31'd0, data_valid_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_inb", {31'd0, in_bounds}, 32'd0);
    data_valid_in = 1'b0;
    @(negedge clk_in);
    rst = 1'b0;
    repeat (6) @(negedge clk_in);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Latency: sampled at edge N, pulse visible only after edge N+4.
    send(160, 90, 16'h0000, 16'h0000, 1'b1);
    @(posedge clk_in);
    @(negedge clk_in);
    data_valid_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_in);
      #1;
      check($sformatf("latency_%0d", k), {31'd0, data_valid_out}, {31'd0, k == 4});
      check($sformatf("busy_%0d", k), {31'd0, busy}, 32'd1);
    end
    @(posedge clk_in);
    #1;
    check("dvo_single", {31'd0, data_valid_out}, 32'd0);
    check("busy_drop", {31'd0, busy}, 32'd0);
    drain();

    // Directed corner cases, sent back to back.
    send(0,   0,   16'hC800, 16'hC800, 1'b1);
    send(319, 179, 16'h47F3, 16'h47E9, 1'b1);
    send(161, 90,  16'h2A66, 16'h0000, 1'b1);
    send(320, 0,   16'h4800, 16'hC800, 1'b0);
    send(0,   180, 16'hC800, 16'h4800, 1'b0);
    idle();
    drain();

    // Five consecutive inputs produce five consecutive pulses in order.
    for (int i = 0; i < 5; i++) send_ref(100 + 37 * i, 20 + 29 * i);
    idle();
    repeat (3) @(negedge clk_in);
    check("stream_pulse", {31'd0, data_valid_out}, 32'd1);
    drain();
    @(negedge clk_in);
    check("stream_busy_idle", {31'd0, busy}, 32'd0);

    // Reset with three samples in flight drops them all.
    send(10, 10, 16'h0000, 16'h0000, 1'b1);
    send(20, 20, 16'h0000, 16'h0000, 1'b1);
    send(30, 30, 16'h0000, 16'h0000, 1'b1);
    @(posedge clk_in);
    #2;
    check("inflight_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_dvo", {31'd0, data_valid_out}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_inb", {31'd0, in_bounds}, 32'd0);
    exp_q.delete();
    data_valid_in = 1'b0;
    @(negedge clk_in);
    rst = 1'b0;
    repeat (10) @(negedge clk_in);
    check("after_rst_busy", {31'd0, busy}, 32'd0);

    // Random vectors against the reference model.
    for (int i = 0; i < 60; i++) send_ref(int'($urandom_range(399, 0)), int'($urandom_range(399, 0)));
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
